// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline hazard controller
package pipe_ctrl_pkg;
  typedef enum logic {RUN, DROP} hz_state_e;
  typedef enum logic [1:0] {FWD_RF, FWD_W, FWD_A, FWD_M} fwd_sel_e;
  localparam int REG_X0 = 0;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: pipeline status in, stall/flush/forward control out
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W  = 32,
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdA, RdW;
  logic              UseRs1D, UseRs2D;
  logic              RegWriteE, RegWriteM, RegWriteA, RegWriteW;
  logic              MemReadE, MemReadM;
  logic              MispredictE, ImemValidF, DmemReqM, DmemGntM;
  logic              StallF, StallD, StallE, StallM;
  logic              FlushD, FlushE, FlushA;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              ImemDiscardF;
  logic [CNT_W-1:0]  StallCnt, FlushCnt;
  modport master (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdA, RdW, UseRs1D, UseRs2D,
           RegWriteE, RegWriteM, RegWriteA, RegWriteW, MemReadE, MemReadM,
           MispredictE, ImemValidF, DmemReqM, DmemGntM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushA,
           ForwardAE, ForwardBE, ImemDiscardF, StallCnt, FlushCnt
  );
  modport slave (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdA, RdW, UseRs1D, UseRs2D,
           RegWriteE, RegWriteM, RegWriteA, RegWriteW, MemReadE, MemReadM,
           MispredictE, ImemValidF, DmemReqM, DmemGntM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushA,
           ForwardAE, ForwardBE, ImemDiscardF, StallCnt, FlushCnt
  );
endinterface

// File: rtl/pipe_fwd_sel.sv
// pipe_fwd_sel: pick the youngest writer of one E-stage source operand
module pipe_fwd_sel
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_i,
  input  logic [REG_AW-1:0] rd_m_i,
  input  logic [REG_AW-1:0] rd_a_i,
  input  logic [REG_AW-1:0] rd_w_i,
  input  logic              we_m_i,
  input  logic              we_a_i,
  input  logic              we_w_i,
  input  logic              mem_read_m_i,
  output fwd_sel_e          sel_o
);
  localparam logic [REG_AW-1:0] X0 = REG_AW'(REG_X0);
  logic hit_m, hit_a, hit_w;
  // load data is not ready in M, so M only forwards ALU results
  always_comb begin
    hit_m = we_m_i && !mem_read_m_i && rd_m_i != X0 && rd_m_i == rs_i;
    hit_a = we_a_i && rd_a_i != X0 && rd_a_i == rs_i;
    hit_w = we_w_i && rd_w_i != X0 && rd_w_i == rs_i;
    sel_o = hit_m ? FWD_M : hit_a ? FWD_A : hit_w ? FWD_W : FWD_RF;
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush priority, fetch-drop FSM, forwarding and perf counters
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int REG_AW = 5
) (
  input  logic               clk,
  input  logic               n_rst,
  pipe_hazard_ctrl_if.master bus
);
  localparam logic [REG_AW-1:0] X0 = REG_AW'(REG_X0);
  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic             dmem_wait, mp_acc, lu_e, lu_m, load_use, drop, fetch_wait;
  logic             stall_f, stall_d, stall_em, flush_d, flush_e, discard;
  fwd_sel_e         fwd_a, fwd_b;
  logic             unused_reg_write_e;

  assign unused_reg_write_e = bus.RegWriteE;

  pipe_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .rs_i(bus.Rs1E), .rd_m_i(bus.RdM), .rd_a_i(bus.RdA), .rd_w_i(bus.RdW),
    .we_m_i(bus.RegWriteM), .we_a_i(bus.RegWriteA), .we_w_i(bus.RegWriteW),
    .mem_read_m_i(bus.MemReadM), .sel_o(fwd_a)
  );

  pipe_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .rs_i(bus.Rs2E), .rd_m_i(bus.RdM), .rd_a_i(bus.RdA), .rd_w_i(bus.RdW),
    .we_m_i(bus.RegWriteM), .we_a_i(bus.RegWriteA), .we_w_i(bus.RegWriteW),
    .mem_read_m_i(bus.MemReadM), .sel_o(fwd_b)
  );

  // a redirect stalled by dmem wait is not accepted and leaves state untouched
  always_comb begin
    dmem_wait   = bus.DmemReqM && !bus.DmemGntM;
    mp_acc      = bus.MispredictE && !dmem_wait;
    lu_e        = bus.MemReadE && bus.RdE != X0 &&
                  ((bus.UseRs1D && bus.Rs1D == bus.RdE) || (bus.UseRs2D && bus.Rs2D == bus.RdE));
    lu_m        = bus.MemReadM && bus.RdM != X0 &&
                  ((bus.UseRs1D && bus.Rs1D == bus.RdM) || (bus.UseRs2D && bus.Rs2D == bus.RdM));
    load_use    = lu_e || lu_m;
    drop        = state_q == DROP;
    fetch_wait  = !bus.ImemValidF || drop;
    stall_f     = n_rst && (dmem_wait || (!mp_acc && (load_use || fetch_wait)));
    stall_d     = n_rst && (dmem_wait || (!mp_acc && load_use));
    stall_em    = n_rst && dmem_wait;
    flush_d     = n_rst && !dmem_wait && (mp_acc || (!load_use && fetch_wait));
    flush_e     = n_rst && (mp_acc || (!dmem_wait && load_use));
    discard     = n_rst && drop && bus.ImemValidF;
    state_d     = ((mp_acc && (drop || !bus.ImemValidF)) || (drop && !bus.ImemValidF)) ? DROP : RUN;
    stall_cnt_d = stall_cnt_q + CNT_W'(stall_f);
    flush_cnt_d = flush_cnt_q + CNT_W'(mp_acc);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.StallF       = stall_f;
  assign bus.StallD       = stall_d;
  assign bus.StallE       = stall_em;
  assign bus.StallM       = stall_em;
  assign bus.FlushD       = flush_d;
  assign bus.FlushE       = flush_e;
  assign bus.FlushA       = stall_em;
  assign bus.ImemDiscardF = discard;
  assign bus.ForwardAE    = n_rst ? fwd_a : FWD_RF;
  assign bus.ForwardBE    = n_rst ? fwd_b : FWD_RF;
  assign bus.StallCnt     = stall_cnt_q;
  assign bus.FlushCnt     = flush_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of hazard priority, forwarding, drop FSM and counters
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic n_rst;
  int   n_pass = 0;
  int   n_tot = 0;
  logic [7:0] ctl;

  pipe_hazard_ctrl_if #(.CNT_W(4), .REG_AW(5)) b ();
  pipe_hazard_ctrl #(.CNT_W(4), .REG_AW(5)) dut (.clk(clk), .n_rst(n_rst), .bus(b));

  always #5 clk = ~clk;

  assign ctl = {b.StallF, b.StallD, b.StallE, b.StallM, b.FlushD, b.FlushE, b.FlushA, b.ImemDiscardF};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    {b.Rs1D, b.Rs2D, b.Rs1E, b.Rs2E, b.RdE, b.RdM, b.RdA, b.RdW} = '0;
    {b.UseRs1D, b.UseRs2D, b.RegWriteE, b.RegWriteM, b.RegWriteA, b.RegWriteW} = '0;
    {b.MemReadE, b.MemReadM, b.MispredictE, b.DmemReqM, b.DmemGntM} = '0;
    b.ImemValidF = 1'b1;
  endtask

  initial begin
    n_rst = 1'b0;
    idle();
    b.DmemReqM = 1; b.MispredictE = 1; b.ImemValidF = 0;
    b.RegWriteM = 1; b.RdM = 3; b.Rs1E = 3;
    b.MemReadE = 1; b.RdE = 2; b.Rs1D = 2; b.UseRs1D = 1;
    #1 chk("rst_ctl", ctl, 0);
    chk("rst_fwd", b.ForwardAE, 0);
    nxt(); nxt();
    chk("rst_ctl_held", ctl, 0);
    n_rst = 1'b1;
    idle();
    #1 chk("post_rst_ctl", ctl, 0);
    chk("post_rst_sc", b.StallCnt, 0);
    chk("post_rst_fc", b.FlushCnt, 0);
    // forwarding priority
    nxt();
    b.RegWriteM = 1; b.RegWriteA = 1; b.RegWriteW = 1;
    b.RdM = 7; b.RdA = 7; b.RdW = 7; b.Rs2E = 7; b.Rs1E = 7;
    #1 chk("fwd_b_m", b.ForwardBE, 2'b11);
    chk("fwd_a_m", b.ForwardAE, 2'b11);
    b.RdM = 0;
    #1 chk("fwd_b_rdm_x0", b.ForwardBE, 2'b10);
    b.RdM = 7; b.MemReadM = 1;
    #1 chk("fwd_b_load_m", b.ForwardBE, 2'b10);
    b.RegWriteA = 0;
    #1 chk("fwd_b_w", b.ForwardBE, 2'b01);
    b.Rs2E = 0;
    #1 chk("fwd_b_x0", b.ForwardBE, 2'b00);
    chk("fwd_a_w", b.ForwardAE, 2'b01);
    // load-use, load in E: two stall cycles then forward from A
    nxt(); idle();
    b.MemReadE = 1; b.RdE = 5; b.RegWriteE = 1; b.Rs1D = 5; b.UseRs1D = 1;
    #1 chk("lu_e1", ctl, 8'b1100_0100);
    nxt();
    b.MemReadE = 0; b.RdE = 0; b.RegWriteE = 0; b.MemReadM = 1; b.RdM = 5; b.RegWriteM = 1;
    #1 chk("lu_e2", ctl, 8'b1100_0100);
    nxt(); idle();
    b.RdA = 5; b.RegWriteA = 1; b.Rs1E = 5;
    #1 chk("lu_done", ctl, 0);
    chk("lu_fwd_a", b.ForwardAE, 2'b10);
    chk("lu_sc", b.StallCnt, 2);
    b.MemReadE = 1; b.RdE = 0; b.Rs1D = 0; b.UseRs1D = 1;
    #1 chk("lu_x0", ctl, 0);
    b.RdE = 6; b.Rs2D = 6; b.UseRs2D = 0;
    #1 chk("lu_unused_rs", ctl, 0);
    nxt(); idle();
    b.MemReadM = 1; b.RdM = 9; b.RegWriteM = 1; b.Rs2D = 9; b.UseRs2D = 1;
    #1 chk("lu_m_rs2", ctl, 8'b1100_0100);
    nxt(); idle();
    #1 chk("lu_m_done", ctl, 0);
    chk("lu_m_sc", b.StallCnt, 3);
    // dmem wait masks a mispredict for three cycles
    nxt(); idle();
    b.DmemReqM = 1; b.MispredictE = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("dmem_wait", ctl, 8'b1111_0010);
      nxt();
    end
    b.DmemGntM = 1;
    #1 chk("dmem_gnt", ctl, 8'b0000_1100);
    chk("dmem_fc0", b.FlushCnt, 0);
    chk("dmem_sc", b.StallCnt, 6);
    nxt(); idle();
    #1 chk("dmem_fc1", b.FlushCnt, 1);
    chk("dmem_idle", ctl, 0);
    // mispredict with fetch outstanding enters DROP
    nxt();
    b.MispredictE = 1; b.ImemValidF = 0;
    #1 chk("drop_enter", ctl, 8'b0000_1100);
    nxt(); idle();
    b.ImemValidF = 0;
    #1 chk("drop_wait", ctl, 8'b1000_1000);
    nxt(); idle();
    #1 chk("drop_resp", ctl, 8'b1000_1001);
    nxt(); idle();
    #1 chk("drop_exit", ctl, 0);
    chk("drop_sc", b.StallCnt, 8);
    chk("drop_fc", b.FlushCnt, 2);
    // mispredict while in DROP keeps DROP
    b.MispredictE = 1; b.ImemValidF = 0;
    #1 chk("drop2_enter", ctl, 8'b0000_1100);
    nxt();
    b.MispredictE = 1; b.ImemValidF = 1;
    #1 chk("drop_mp", ctl, 8'b0000_1101);
    nxt(); idle();
    #1 chk("drop_stay", ctl, 8'b1000_1001);
    nxt(); idle();
    #1 chk("drop2_exit", ctl, 0);
    // dmem wait suppresses the redirect, so no DROP
    b.DmemReqM = 1; b.MispredictE = 1; b.ImemValidF = 0;
    #1 chk("dmem_no_drop", ctl, 8'b1111_0010);
    nxt(); idle();
    #1 chk("no_drop_run", ctl, 0);
    chk("no_drop_fc", b.FlushCnt, 4);
    // load-use vs mispredict, fetch wait vs load-use
    b.MemReadM = 1; b.RdM = 4; b.RegWriteM = 1; b.Rs1D = 4; b.UseRs1D = 1; b.MispredictE = 1;
    #1 chk("lu_vs_mp", ctl, 8'b0000_1100);
    nxt(); idle();
    b.ImemValidF = 0;
    #1 chk("fetch_wait", ctl, 8'b1000_1000);
    nxt();
    b.MemReadM = 1; b.RdM = 4; b.RegWriteM = 1; b.Rs1D = 4; b.UseRs1D = 1;
    #1 chk("lu_vs_fw", ctl, 8'b1100_0100);
    nxt(); idle();
    #1 chk("pre_wrap_sc", b.StallCnt, 12);
    chk("pre_wrap_fc", b.FlushCnt, 5);
    b.ImemValidF = 0;
    repeat (4) nxt();
    idle();
    #1 chk("sc_wrap", b.StallCnt, 0);
    // reset while in DROP with stalls active
    b.MispredictE = 1; b.ImemValidF = 0;
    nxt(); idle();
    b.ImemValidF = 0;
    #1 chk("rst_drop_pre", ctl, 8'b1000_1000);
    nxt();
    chk("rst_drop_sc", b.StallCnt, 1);
    chk("rst_drop_fc", b.FlushCnt, 6);
    n_rst = 1'b0;
    #1 chk("rst_drop_ctl", ctl, 0);
    nxt();
    n_rst = 1'b1; b.ImemValidF = 1;
    #1 chk("rst_drop_run", ctl, 0);
    chk("rst_drop_sc0", b.StallCnt, 0);
    chk("rst_drop_fc0", b.FlushCnt, 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
